// File: rtl/float2int_pipe.sv
// Pipelined IEEE-754 single-precision to signed fixed-point converter with valid/ready flow control.
// Define FLOAT2INT_RNE_EN for round-to-nearest-even; otherwise the magnitude truncates toward zero.
module float2int_pipe #(
  parameter int MAN   = 23,
  parameter int EXP   = 8,
  parameter int OUT_W = 23,
  parameter int FRAC  = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [MAN+EXP:0]        f_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] q_out,
  output logic                    sat_flag,
  output logic                    nan_flag,
  output logic [15:0]             sat_count
);

  localparam int BIAS = 2 ** (EXP - 1) - 1;
  localparam int WW   = OUT_W + MAN + 1;

  localparam logic [OUT_W:0]   POS_LIM = {2'b00, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W:0]   NEG_LIM = {2'b01, {(OUT_W-1){1'b0}}};
  localparam logic [OUT_W-1:0] Q_MAX   = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] Q_MIN   = {1'b1, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {
    CLS_NORM,
    CLS_ZERO,
    CLS_INF,
    CLS_NAN
  } cls_e;

  logic en;

  // Stage 1: unpack
  logic           f_sign;
  logic [EXP-1:0] f_exp;
  logic [MAN-1:0] f_man;
  cls_e           f_cls;

  logic           s1_valid;
  logic           s1_sign;
  logic [EXP-1:0] s1_exp;
  logic [MAN:0]   s1_mant;
  cls_e           s1_cls;

  // Stage 2: align
  int             shift;
  logic [WW-1:0]  al_wide;
  logic           al_ovf;

  logic             s2_valid;
  logic             s2_sign;
  cls_e             s2_cls;
  logic [OUT_W-1:0] s2_mag;
  logic             s2_ovf;

  // Stage 3: round
  logic [OUT_W:0] rnd_mag;

  logic           s3_valid;
  logic           s3_sign;
  cls_e           s3_cls;
  logic [OUT_W:0] s3_mag;
  logic           s3_ovf;

  // Output: sign and saturate
  logic signed [OUT_W-1:0] res_q;
  logic                    res_sat;
  logic                    res_nan;

`ifdef FLOAT2INT_RNE_EN
  logic         al_guard;
  logic         al_sticky;
  logic [MAN:0] guard_mask;
  logic [MAN:0] low_mask;
  logic         s2_guard;
  logic         s2_sticky;
  logic         round_up;
`endif

  // The whole pipe moves in lock-step; a stalled output freezes every stage.
  assign en       = ~out_valid | out_ready;
  assign in_ready = en;

  assign f_sign = f_in[MAN+EXP];
  assign f_exp  = f_in[MAN+EXP-1:MAN];
  assign f_man  = f_in[MAN-1:0];

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    f_cls = CLS_NORM;
    if (f_exp == '0) begin
      f_cls = CLS_ZERO;
    end else if (&f_exp) begin
      f_cls = (f_man == '0) ? CLS_INF : CLS_NAN;
    end
  end

  // Align the 1.mantissa to the output LSB; the right-shift path also yields rounding bits.
  always_comb begin
    shift   = int'(s1_exp) - BIAS - MAN + FRAC;
    al_wide = '0;
    al_ovf  = 1'b0;
`ifdef FLOAT2INT_RNE_EN
    al_guard   = 1'b0;
    al_sticky  = 1'b0;
    guard_mask = '0;
    low_mask   = '0;
`endif
    if (shift >= 0) begin
      if (shift >= OUT_W - MAN) begin
        al_ovf = 1'b1;
      end else begin
        al_wide = WW'(s1_mant) << shift;
      end
    end else if (-shift > MAN + 2) begin
`ifdef FLOAT2INT_RNE_EN
      al_sticky = |s1_mant;
`endif
    end else begin
      al_wide = WW'(s1_mant >> (-shift));
      al_ovf  = |al_wide[WW-1:OUT_W];
`ifdef FLOAT2INT_RNE_EN
      // Guard is the first bit shifted out; sticky ORs everything below it.
      guard_mask = ({(MAN+1){1'b1}} << (-shift - 1)) ^ ({(MAN+1){1'b1}} << (-shift));
      low_mask   = ~({(MAN+1){1'b1}} << (-shift - 1));
      al_guard   = |(s1_mant & guard_mask);
      al_sticky  = |(s1_mant & low_mask);
`endif
    end
  end

`ifdef FLOAT2INT_RNE_EN
  assign round_up = s2_guard & (s2_sticky | s2_mag[0]);
  assign rnd_mag  = {1'b0, s2_mag} + {{OUT_W{1'b0}}, round_up};
`else
  assign rnd_mag  = {1'b0, s2_mag};
`endif

  // A carry out of rounding shows up as a magnitude beyond the limits and saturates like any other.
  always_comb begin
    res_q   = '0;
    res_sat = 1'b0;
    res_nan = 1'b0;
    case (s3_cls)
      CLS_ZERO: res_q = '0;
      CLS_NAN:  res_nan = 1'b1;
      CLS_INF: begin
        res_sat = 1'b1;
        res_q   = s3_sign ? Q_MIN : Q_MAX;
      end
      default: begin
        if (!s3_sign) begin
          if (s3_ovf || s3_mag > POS_LIM) begin
            res_sat = 1'b1;
            res_q   = Q_MAX;
          end else begin
            res_q = s3_mag[OUT_W-1:0];
          end
        end else begin
          if (s3_ovf || s3_mag > NEG_LIM) begin
            res_sat = 1'b1;
            res_q   = Q_MIN;
          end else begin
            res_q = -$signed(s3_mag[OUT_W-1:0]);
          end
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      s3_valid  <= 1'b0;
      out_valid <= 1'b0;
      q_out     <= '0;
      sat_flag  <= 1'b0;
      nan_flag  <= 1'b0;
    end else if (en) begin
      s1_valid  <= in_valid;
      s2_valid  <= s1_valid;
      s3_valid  <= s2_valid;
      out_valid <= s3_valid;
      if (s3_valid) begin
        q_out    <= res_q;
        sat_flag <= res_sat;
        nan_flag <= res_nan;
      end
    end
  end

  // NOTE: datapath registers carry no reset; the valid bits alone decide whether their contents matter.
  always_ff @(posedge clk) begin
    if (en) begin
      s1_sign <= f_sign;
      s1_exp  <= f_exp;
      s1_mant <= {1'b1, f_man};
      s1_cls  <= f_cls;

      s2_sign <= s1_sign;
      s2_cls  <= s1_cls;
      s2_mag  <= al_wide[OUT_W-1:0];
      s2_ovf  <= al_ovf;
`ifdef FLOAT2INT_RNE_EN
      s2_guard  <= al_guard;
      s2_sticky <= al_sticky;
`endif

      s3_sign <= s2_sign;
      s3_cls  <= s2_cls;
      s3_mag  <= rnd_mag;
      s3_ovf  <= s2_ovf;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_count <= '0;
    end else if (out_valid && out_ready && sat_flag && sat_count != 16'hFFFF) begin
      sat_count <= sat_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_float2int_pipe.sv
// Self-checking bench for float2int_pipe: arithmetic reference model, per-cycle output compare,
// directed value/backpressure/reset scenarios and randomized streams.
module tb_float2int_pipe;

  localparam int     OUT_W = 23;
  localparam int     FRAC  = 0;
  localparam longint Q_MAX = (longint'(1) << (OUT_W - 1)) - 1;
  localparam longint Q_MIN = -(longint'(1) << (OUT_W - 1));

  logic                    clk = 1'b0;
  logic                    rst = 1'b0;
  logic                    in_valid = 1'b0;
  logic                    in_ready;
  logic [31:0]             f_in = '0;
  logic                    out_valid;
  logic                    out_ready = 1'b1;
  logic signed [OUT_W-1:0] q_out;
  logic                    sat_flag;
  logic                    nan_flag;
  logic [15:0]             sat_count;

  float2int_pipe #(.MAN(23), .EXP(8), .OUT_W(OUT_W), .FRAC(FRAC)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .f_in      (f_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q_out     (q_out),
    .sat_flag  (sat_flag),
    .nan_flag  (nan_flag),
    .sat_count (sat_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic signed [63:0] q;
    logic               sat;
    logic               nan;
  } exp_t;

  exp_t exp_q[$];
  int   m_cnt = 0;
  int   total = 0;
  int   bad   = 0;
  bit   mon_en = 1'b0;

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Value of the float as exact integer arithmetic, then rounding and clamping.
  function automatic exp_t model(input logic [31:0] f);
    exp_t   r;
    int     e;
    int     sh;
    longint m;
    longint mag;
    longint fl;
    longint v;
    bit     ovf;
    r   = '0;
    e   = int'(f[30:23]);
    m   = longint'({1'b1, f[22:0]});
    mag = 0;
    ovf = 1'b0;
    if (e == 0) return r;
    if (e == 255) begin
      if (f[22:0] != 0) begin
        r.nan = 1'b1;
      end else begin
        r.sat = 1'b1;
        r.q   = f[31] ? Q_MIN : Q_MAX;
      end
      return r;
    end
    sh = e - 150 + FRAC;
    if (sh >= 0) begin
      if (sh > 30) ovf = 1'b1;
      else mag = m << sh;
    end else if (-sh <= 40) begin
      fl  = m >> (-sh);
      mag = fl;
`ifdef FLOAT2INT_RNE_EN
      begin
        longint rem;
        longint half;
        rem  = m - (fl << (-sh));
        half = longint'(1) << (-sh - 1);
        if (rem > half || (rem == half && fl[0])) mag = fl + 1;
      end
`endif
    end
    v = f[31] ? -mag : mag;
    if (ovf) begin
      r.sat = 1'b1;
      r.q   = f[31] ? Q_MIN : Q_MAX;
    end else if (v > Q_MAX) begin
      r.sat = 1'b1;
      r.q   = Q_MAX;
    end else if (v < Q_MIN) begin
      r.sat = 1'b1;
      r.q   = Q_MIN;
    end else begin
      r.q = v;
    end
    return r;
  endfunction

  task automatic pin(input string name, input logic [31:0] f, input longint q, input bit sat, input bit nan);
    exp_t e;
    e = model(f);
    check({name, "_q"}, e.q, q);
    check({name, "_sat"}, e.sat, sat);
    check({name, "_nan"}, e.nan, nan);
  endtask

  function automatic logic [31:0] rand_float();
    logic [7:0]  e;
    logic [22:0] man;
    int          pick;
    pick = $urandom_range(0, 9);
    man  = 23'($urandom);
    if (pick == 0) e = 8'd0;
    else if (pick == 1) e = 8'hFF;
    else if (pick < 4) e = 8'($urandom_range(0, 255));
    else e = 8'($urandom_range(120, 152));
    if (pick == 9) man = man & 23'h7FFF00;
    return {1'($urandom), e, man};
  endfunction

  // Compare process: every non-reset cycle, sampled on the falling edge.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      check("sat_count", sat_count, m_cnt);
      if (out_valid) begin
        check("in_ready_busy", in_ready, out_ready);
        if (exp_q.size() == 0) begin
          check("spurious_out_valid", out_valid, 1'b0);
        end else begin
          check("q_out", q_out, exp_q[0].q);
          check("sat_flag", sat_flag, exp_q[0].sat);
          check("nan_flag", nan_flag, exp_q[0].nan);
          if (out_ready) begin
            if (exp_q[0].sat && m_cnt < 65535) m_cnt++;
            void'(exp_q.pop_front());
          end
        end
      end else begin
        check("in_ready_idle", in_ready, 1'b1);
      end
      if (in_valid && in_ready) exp_q.push_back(model(f_in));
    end
  end

  // mode 0: always ready; mode 1: 4-cycle stall after first output; mode 2: random gaps and backpressure
  task automatic run_stream(input logic [31:0] vals[$], input int mode);
    int idx;
    int cyc;
    int first_ov;
    int budget;
    idx      = 0;
    cyc      = 0;
    first_ov = -1;
    budget   = 20 * vals.size() + 60;
    while ((idx < vals.size() || exp_q.size() > 0 || out_valid) && cyc < budget) begin
      @(posedge clk);
      #1;
      case (mode)
        1:       out_ready = !(first_ov >= 0 && cyc > first_ov && cyc <= first_ov + 4);
        2:       out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = 1'b1;
      endcase
      if (idx < vals.size() && (mode != 2 || $urandom_range(0, 4) != 0)) begin
        in_valid = 1'b1;
        f_in     = vals[idx];
      end else begin
        in_valid = 1'b0;
        f_in     = $urandom;
      end
      @(negedge clk);
      if (out_valid && first_ov < 0) first_ov = cyc;
      if (in_valid && in_ready) idx++;
      cyc++;
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("stream_in_budget", cyc < budget, 1'b1);
    check("queue_drained", exp_q.size(), 0);
  endtask

  logic [31:0] dir_vals [11] = '{
    32'h40490FDB, 32'hC0200000, 32'h40300000, 32'h40600000, 32'h40200000, 32'h4B000000,
    32'hCA800000, 32'h4A7FFFFE, 32'h7FC00000, 32'hFF800000, 32'h00000001
  };
  logic [31:0] bp_vals [6] = '{
    32'h40490FDB, 32'h4B000000, 32'hC0200000, 32'h40600000, 32'hFF800000, 32'h7FC00000
  };
  logic [31:0] rs_vals [4] = '{32'h40490FDB, 32'h4B000000, 32'hC0200000, 32'h40600000};

  initial begin
    logic [31:0] v[$];
    int k;

    // Hand-computed anchors for the model.
    pin("pi",      32'h40490FDB, 3, 1'b0, 1'b0);
    pin("m2p5",    32'hC0200000, -2, 1'b0, 1'b0);
    pin("p2p5",    32'h40200000, 2, 1'b0, 1'b0);
    pin("two23",   32'h4B000000, 64'h3FFFFF, 1'b1, 1'b0);
    pin("neg_min", 32'hCA800000, -4194304, 1'b0, 1'b0);
    pin("nan",     32'h7FC00000, 0, 1'b0, 1'b1);
    pin("neg_inf", 32'hFF800000, -4194304, 1'b1, 1'b0);
    pin("denorm",  32'h00000001, 0, 1'b0, 1'b0);
`ifdef FLOAT2INT_RNE_EN
    pin("p2p75",   32'h40300000, 3, 1'b0, 1'b0);
    pin("p3p5",    32'h40600000, 4, 1'b0, 1'b0);
    pin("near_max", 32'h4A7FFFFE, 64'h3FFFFF, 1'b1, 1'b0);
`else
    pin("p2p75",   32'h40300000, 2, 1'b0, 1'b0);
    pin("p3p5",    32'h40600000, 3, 1'b0, 1'b0);
    pin("near_max", 32'h4A7FFFFE, 4194303, 1'b0, 1'b0);
`endif

    // Asynchronous reset before any clock edge.
    #1 rst = 1'b1;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_sat_count", sat_count, 0);
    check("rst_q_out", q_out, 0);
    check("rst_in_ready", in_ready, 1'b1);
    @(negedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    mon_en = 1'b1;

    // Directed values.
    v.delete();
    foreach (dir_vals[i]) v.push_back(dir_vals[i]);
    run_stream(v, 0);

    // Backpressure: 6 back-to-back with a 4-cycle stall.
    v.delete();
    foreach (bp_vals[i]) v.push_back(bp_vals[i]);
    run_stream(v, 1);

    // Reset mid-stream with sat_count at 2.
    @(negedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    m_cnt = 0;
    @(negedge clk);
    #1 rst = 1'b0;
    v.delete();
    v.push_back(32'h4B000000);
    v.push_back(32'hFF800000);
    run_stream(v, 0);
    check("pre_reset_sat_count", sat_count, 2);
    foreach (rs_vals[i]) begin
      in_valid = 1'b1;
      f_in     = rs_vals[i];
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    #1;
    check("pre_reset_out_valid", out_valid, 1'b1);
    rst = 1'b1;
    exp_q.delete();
    m_cnt = 0;
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_sat_count", sat_count, 0);
    check("midrst_q_out", q_out, 0);
    check("midrst_in_ready", in_ready, 1'b1);
    @(negedge clk);
    #1 rst = 1'b0;

    // Latency after release: edges counted after the accepting edge.
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    f_in     = 32'h40490FDB;
    @(negedge clk);
    check("accept_after_reset", in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 10) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("latency", k, 3);
    repeat (3) @(posedge clk);
    check("latency_drained", exp_q.size(), 0);

    // Randomized streams.
    v.delete();
    for (int i = 0; i < 300; i++) v.push_back(rand_float());
    run_stream(v, 2);
    v.delete();
    for (int i = 0; i < 200; i++) v.push_back(rand_float());
    run_stream(v, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
